seq_mult_acc: RTL and testbench
===============================

# seq_mult_acc

Parametrised iterative shift-add multiplier with operand registers, a start/busy/done handshake, an optional signed mode and an optional accumulate mode. It generalises the team's fixed 8x8 combinational board multiplier: operand width is a parameter, the product takes one clock per operand bit instead of a wide combinational array, and products can be summed into a guarded accumulator with sticky overflow. It sits between the switch/key input logic and the hexto7segment display drivers.

## Interface
- WIDTH, 8, operand width in bits (≥2)
- ACC_EXT, 4, accumulator guard bits above 2*WIDTH
- Clock  in  1  single clock, all state updates on rising edge
- Resetn  in  1  asynchronous, active-low reset
- DataIn  in  WIDTH  operand data
- LoadA  in  1  load DataIn into operand A
- LoadB  in  1  load DataIn into operand B
- Start  in  1  begin a multiply of current A, B
- Signed  in  1  1 = two's-complement operands/product; sampled with Start
- Accumulate  in  1  1 = add product into Acc at completion; sampled with Start
- ClearAcc  in  1  synchronous clear of Acc and Overflow
- Busy  out  1  operation in progress
- Done  out  1  one-cycle completion pulse
- Product  out  2*WIDTH  last completed product, held until next completion
- Acc  out  2*WIDTH+ACC_EXT  accumulator, wraps modulo 2^(2*WIDTH+ACC_EXT)
- Overflow  out  1  sticky accumulator overflow flag

## Operation
- Reset: A, B, Product, Acc, Overflow = 0; Busy = 0; Done = 0; state IDLE. Reset mid-operation aborts it; no Done follows.
- Loads: LoadA/LoadB honoured only when Busy=0; both may load on the same edge from the same DataIn. Loads while Busy=1 are ignored.
- Start honoured only when Busy=0; ignored otherwise (no queuing). Start coincident with a load uses the pre-load A/B; the new value lands for the next operation.
- States: IDLE → RUN on Start. RUN iterates WIDTH times: if multiplier LSB = 1 add multiplicand to upper partial product, then shift right one bit. RUN → FIX after the WIDTH-th iteration. FIX → IDLE unconditionally, writing Product, updating Acc, pulsing Done.
- Signed mode: Start latches magnitudes of A and B and the sign XOR; FIX negates the magnitude product if the sign XOR = 1. Most-negative operands are handled as unsigned magnitude 2^(WIDTH-1). Unsigned mode: FIX passes the product unchanged.
- Accumulate (latched): at FIX, Acc ← Acc + Product, with Product sign-extended (signed) or zero-extended (unsigned). Overflow sets on unsigned carry-out (unsigned) or two's-complement overflow (signed) and stays set until ClearAcc or reset.
- ClearAcc on any edge forces Acc = 0, Overflow = 0. If coincident with the FIX edge, the clear wins for Acc/Overflow; Product and Done still update.

## Timing
- Start sampled at edge 0: Busy = 1 after edge 0; RUN iterations on edges 1..WIDTH; FIX edge WIDTH+1; Product/Acc valid and Done = 1, Busy = 0 for the cycle after edge WIDTH+1.
- Start-to-Done latency WIDTH+2 edges (10 for WIDTH=8). Back-to-back throughput: one product per WIDTH+2 cycles; a Start held high through Done is accepted on the edge after Done.
- Outputs are registered; no combinational path from inputs to outputs.

## Structure
- Package seq_mult_pkg: state enum (IDLE, RUN, FIX) and a width helper function for 2*WIDTH+ACC_EXT.
- One sub-module seq_mult_ctrl: FSM and iteration counter ($clog2(WIDTH+1) bits), emitting busy/done/step/finish strobes. Datapath (operand regs, partial product, sign fix, accumulator) stays in seq_mult_acc.

## Test plan
- WIDTH=8 unsigned: A=0xFF, B=0xFF, Start → Done on 10th edge, Product = 0xFE01, Busy low with Done.
- Signed: A=0x80, B=0x80 → Product = 0x4000; A=0xFF, B=0x05 → Product = 0xFFFB; same operands unsigned → 0x04FB.
- Accumulate unsigned, ACC_EXT=4: three runs of 100×100 → Acc = 0x07530, Overflow = 0; after ClearAcc, seventeen runs of 0xFF×0xFF → Acc = 0x0DE11, Overflow = 1 after the 17th Done.
- Protocol: Start and LoadA=0x12 asserted on edge 3 of a running op → both ignored, Product unaffected, A unchanged; Start coincident with LoadB in IDLE → uses old B.
- Resetn low after edge 4 of a run → all outputs 0 immediately, no Done; ClearAcc on the FIX edge with Accumulate=1 → Acc = 0, Product updated, Done pulses.

Source files
------------

// File: rtl/seq_mult_pkg.sv
// Shared types for the iterative multiply-accumulate block.
// Latency: n/a (types and constant helpers only).
// Backpressure: n/a.
package seq_mult_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      FIX  = 2'd2
   } state_t;

   // Accumulator width: full product plus guard bits.
   function automatic int acc_width(input int width, input int ext);
      return 2 * width + ext;
   endfunction

endpackage

// File: rtl/seq_mult_acc_if.sv
// Operand / control / result bundle between input logic and the multiplier.
// Latency: n/a (wiring only).
// Backpressure: none; start is dropped while busy, so the driver watches busy.
interface seq_mult_acc_if #(
   parameter int WIDTH   = 8,
   parameter int ACC_EXT = 4
);
   import seq_mult_pkg::*;

   localparam int AW = acc_width(WIDTH, ACC_EXT);

   logic [WIDTH-1:0]   data_in;
   logic               load_a;
   logic               load_b;
   logic               start;
   logic               signed_mode;
   logic               accumulate;
   logic               clear_acc;
   logic               busy;
   logic               done;
   logic [2*WIDTH-1:0] product;
   logic [AW-1:0]      acc;
   logic               overflow;

   modport master (
      output data_in, load_a, load_b, start, signed_mode, accumulate, clear_acc,
      input  busy, done, product, acc, overflow
   );

   modport slave (
      input  data_in, load_a, load_b, start, signed_mode, accumulate, clear_acc,
      output busy, done, product, acc, overflow
   );

endinterface

// File: rtl/seq_mult_ctrl.sv
// Sequencer for the shift-add multiplier: IDLE -> RUN (WIDTH steps) -> FIX -> IDLE.
// Latency: start accepted at edge 0, finish strobe during the cycle before edge WIDTH+1, done registered after it.
// Backpressure: start only accepted in IDLE; otherwise dropped, never queued.
// Ports: clock/resetn; start in; busy, done, launch (start accepted), step (one iteration), finish (FIX cycle) out.
module seq_mult_ctrl
   import seq_mult_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic clock,
   input  logic resetn,
   input  logic start,
   output logic busy,
   output logic done,
   output logic launch,
   output logic step,
   output logic finish
);

   localparam int CW = $clog2(WIDTH + 1);

   state_t         state_q, state_d;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic           done_q;

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         done_q  <= finish;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      launch  = 1'b0;
      step    = 1'b0;
      finish  = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               launch  = 1'b1;
               cnt_d   = '0;
               state_d = RUN;
            end
         end
         RUN: begin
            step  = 1'b1;
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == CW'(WIDTH - 1)) begin
               state_d = FIX;
            end
         end
         FIX: begin
            finish  = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign busy = (state_q != IDLE);
   assign done = done_q;

endmodule

// File: rtl/seq_mult_acc.sv
// Iterative shift-add multiplier with optional signed mode and guarded, sticky-overflow accumulator.
// Latency: WIDTH+2 edges from accepted start to the done pulse; one product per WIDTH+2 cycles.
// Backpressure: loads and start are ignored while busy; the driver must hold or retry.
// Ports: clock, resetn (async active-low); bus (slave) carries data_in, load_a/b, start, signed_mode,
//        accumulate, clear_acc in and busy, done, product, acc, overflow out.
module seq_mult_acc
   import seq_mult_pkg::*;
#(
   parameter int WIDTH   = 8,
   parameter int ACC_EXT = 4
) (
   input  logic          clock,
   input  logic          resetn,
   seq_mult_acc_if.slave bus
);

   localparam int PW = 2 * WIDTH;
   localparam int AW = acc_width(WIDTH, ACC_EXT);

   logic              busy, done, launch, step, finish;
   logic [WIDTH-1:0]  a_q, b_q, mcand_q, hi_q, lo_q;
   logic              neg_q, sgn_q, accm_q;
   logic [PW-1:0]     product_q;
   logic [AW-1:0]     acc_q;
   logic              ovf_q;

   seq_mult_ctrl #(.WIDTH(WIDTH)) u_ctrl (
      .clock  (clock),
      .resetn (resetn),
      .start  (bus.start),
      .busy   (busy),
      .done   (done),
      .launch (launch),
      .step   (step),
      .finish (finish)
   );

   // Magnitudes for the iteration. The most-negative value negates to itself,
   // which read unsigned is exactly its magnitude 2^(WIDTH-1).
   logic [WIDTH-1:0] mag_a, mag_b;
   assign mag_a = (bus.signed_mode && a_q[WIDTH-1]) ? (~a_q + WIDTH'(1)) : a_q;
   assign mag_b = (bus.signed_mode && b_q[WIDTH-1]) ? (~b_q + WIDTH'(1)) : b_q;

   // One iteration: conditionally add multiplicand into the upper half, then
   // shift {carry, hi, lo} right; the multiplier drains out of lo as product bits fill it.
   logic [WIDTH:0] add_sum;
   assign add_sum = {1'b0, hi_q} + {1'b0, (lo_q[0] ? mcand_q : '0)};

   logic [PW-1:0] prod_mag, prod_fix;
   assign prod_mag = {hi_q, lo_q};
   assign prod_fix = neg_q ? (~prod_mag + PW'(1)) : prod_mag;

   logic [AW-1:0] prod_ext;
   logic [AW:0]   acc_sum;
   logic          ovf_add;
   assign prod_ext = sgn_q ? {{ACC_EXT{prod_fix[PW-1]}}, prod_fix} : {{ACC_EXT{1'b0}}, prod_fix};
   assign acc_sum  = {1'b0, acc_q} + {1'b0, prod_ext};
   // Signed overflow: like-signed operands producing an opposite-signed sum.
   assign ovf_add  = sgn_q ? ((acc_q[AW-1] == prod_ext[AW-1]) && (acc_sum[AW-1] != acc_q[AW-1]))
                           : acc_sum[AW];

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         a_q       <= '0;
         b_q       <= '0;
         mcand_q   <= '0;
         hi_q      <= '0;
         lo_q      <= '0;
         neg_q     <= 1'b0;
         sgn_q     <= 1'b0;
         accm_q    <= 1'b0;
         product_q <= '0;
         acc_q     <= '0;
         ovf_q     <= 1'b0;
      end else begin
         if (!busy) begin
            if (bus.load_a) a_q <= bus.data_in;
            if (bus.load_b) b_q <= bus.data_in;
         end
         // launch reads a_q/b_q before any coincident load lands.
         if (launch) begin
            mcand_q <= mag_a;
            hi_q    <= '0;
            lo_q    <= mag_b;
            neg_q   <= bus.signed_mode & (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
            sgn_q   <= bus.signed_mode;
            accm_q  <= bus.accumulate;
         end
         if (step) begin
            hi_q <= add_sum[WIDTH:1];
            lo_q <= {add_sum[0], lo_q[WIDTH-1:1]};
         end
         if (finish) begin
            product_q <= prod_fix;
         end
         // Clear takes priority over a coincident accumulate.
         if (bus.clear_acc) begin
            acc_q <= '0;
            ovf_q <= 1'b0;
         end else if (finish && accm_q) begin
            acc_q <= acc_sum[AW-1:0];
            ovf_q <= ovf_q | ovf_add;
         end
      end
   end

   assign bus.busy     = busy;
   assign bus.done     = done;
   assign bus.product  = product_q;
   assign bus.acc      = acc_q;
   assign bus.overflow = ovf_q;

endmodule

// File: tb/tb_seq_mult_acc.sv
// Self-checking bench for seq_mult_acc: scoreboard of expected product/acc/overflow per operation.
// Latency: checks WIDTH+2 edge start-to-done.
// Backpressure: exercises ignored start/loads while busy.
module tb_seq_mult_acc;
   import seq_mult_pkg::*;

   localparam int W   = 8;
   localparam int EXT = 4;
   localparam int AW  = acc_width(W, EXT);

   logic clock  = 1'b0;
   logic resetn = 1'b0;
   always #5 clock = ~clock;

   seq_mult_acc_if #(.WIDTH(W), .ACC_EXT(EXT)) bus ();

   seq_mult_acc #(.WIDTH(W), .ACC_EXT(EXT)) dut (
      .clock  (clock),
      .resetn (resetn),
      .bus    (bus)
   );

   typedef struct {
      logic [2*W-1:0] prod;
      logic [AW-1:0]  acc;
      logic           ovf;
   } exp_t;

   exp_t sb[$];
   int   n_vec = 0;
   int   n_bad = 0;

   logic [W-1:0]  m_a   = '0;
   logic [W-1:0]  m_b   = '0;
   logic [AW-1:0] m_acc = '0;
   logic          m_ovf = 1'b0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic load(input logic wa, input logic wb, input logic [W-1:0] v);
      bus.data_in = v;
      bus.load_a  = wa;
      bus.load_b  = wb;
      tick();
      bus.load_a  = 1'b0;
      bus.load_b  = 1'b0;
      if (wa) m_a = v;
      if (wb) m_b = v;
   endtask

   task automatic clear();
      bus.clear_acc = 1'b1;
      tick();
      bus.clear_acc = 1'b0;
      m_acc = '0;
      m_ovf = 1'b0;
      check("clear_acc", bus.acc, 0);
      check("clear_ovf", bus.overflow, 0);
   endtask

   // Reference: plain integer multiply, then a wide-integer accumulate.
   task automatic predict(input logic sgn, input logic accm, input logic clr);
      int     pa, pb, p;
      longint s;
      exp_t   e;
      pa = sgn ? int'($signed(m_a)) : int'(m_a);
      pb = sgn ? int'($signed(m_b)) : int'(m_b);
      p  = pa * pb;
      e.prod = p[2*W-1:0];
      if (clr) begin
         m_acc = '0;
         m_ovf = 1'b0;
      end else if (accm) begin
         if (sgn) begin
            s = longint'($signed(m_acc)) + longint'($signed(e.prod));
            if (s > (longint'(1) << (AW-1)) - 1 || s < -(longint'(1) << (AW-1))) m_ovf = 1'b1;
         end else begin
            s = longint'(m_acc) + longint'(e.prod);
            if (s >= (longint'(1) << AW)) m_ovf = 1'b1;
         end
         m_acc = s[AW-1:0];
      end
      e.acc = m_acc;
      e.ovf = m_ovf;
      sb.push_back(e);
   endtask

   // One operation. ldb: load_b coincident with start. inj: start + load_a=0x12
   // presented for edge 3 of the run. clr_fix: clear_acc on the FIX edge.
   task automatic op(input logic sgn, input logic accm, input logic ldb,
                     input logic [W-1:0] bval, input logic inj, input logic clr_fix);
      logic seen;
      exp_t e;
      predict(sgn, accm, clr_fix);
      bus.signed_mode = sgn;
      bus.accumulate  = accm;
      bus.start       = 1'b1;
      if (ldb) begin
         bus.data_in = bval;
         bus.load_b  = 1'b1;
      end
      tick();
      bus.start  = 1'b0;
      bus.load_b = 1'b0;
      if (ldb) m_b = bval;
      seen = 1'b0;
      for (int k = 1; k <= 20 && !seen; k++) begin
         tick();
         bus.clear_acc = clr_fix && (k == W);
         if (inj) begin
            if (k == 2) begin
               bus.start   = 1'b1;
               bus.load_a  = 1'b1;
               bus.data_in = 8'h12;
            end else begin
               bus.start  = 1'b0;
               bus.load_a = 1'b0;
            end
         end
         if (k == 1) check("busy_run", bus.busy, 1);
         if (bus.done) begin
            seen = 1'b1;
            check("latency", k + 1, W + 2);
            check("busy_at_done", bus.busy, 0);
            if (sb.size() > 0) begin
               e = sb.pop_front();
               check("product", bus.product, e.prod);
               check("acc", bus.acc, e.acc);
               check("overflow", bus.overflow, e.ovf);
            end else begin
               check("sb_nonempty", sb.size(), 1);
            end
         end
      end
      bus.clear_acc = 1'b0;
      bus.start     = 1'b0;
      bus.load_a    = 1'b0;
      check("done_seen", seen, 1);
      tick();
      check("done_pulse", bus.done, 0);
   endtask

   initial begin
      int dcount;
      bus.data_in     = '0;
      bus.load_a      = 1'b0;
      bus.load_b      = 1'b0;
      bus.start       = 1'b0;
      bus.signed_mode = 1'b0;
      bus.accumulate  = 1'b0;
      bus.clear_acc   = 1'b0;
      tick();
      tick();
      check("rst_busy", bus.busy, 0);
      check("rst_done", bus.done, 0);
      check("rst_product", bus.product, 0);
      check("rst_acc", bus.acc, 0);
      check("rst_ovf", bus.overflow, 0);
      resetn = 1'b1;
      tick();

      // Unsigned corner and signed cases.
      load(1, 1, 8'hFF);
      op(0, 0, 0, 0, 0, 0);
      load(1, 1, 8'h80);
      op(1, 0, 0, 0, 0, 0);
      load(1, 0, 8'hFF);
      load(0, 1, 8'h05);
      op(1, 0, 0, 0, 0, 0);
      op(0, 0, 0, 0, 0, 0);

      // Unsigned accumulate, no overflow then overflow on the 17th.
      clear();
      load(1, 1, 8'd100);
      for (int i = 0; i < 3; i++) op(0, 1, 0, 0, 0, 0);
      check("acc_3x100sq", bus.acc, 20'h07530);
      clear();
      load(1, 1, 8'hFF);
      for (int i = 0; i < 17; i++) op(0, 1, 0, 0, 0, 0);
      check("acc_17xfe01", bus.acc, 20'h0DE11);
      check("ovf_17xfe01", bus.overflow, 1);

      // Protocol: start/load while busy ignored; start with load_b uses old B.
      load(1, 0, 8'h03);
      load(0, 1, 8'h07);
      op(0, 0, 0, 0, 1, 0);
      op(0, 0, 0, 0, 0, 0);
      op(0, 0, 1, 8'h09, 0, 0);
      op(0, 0, 0, 0, 0, 0);

      // Signed accumulate: negative running sum, then positive overflow.
      clear();
      load(1, 0, 8'h80);
      load(0, 1, 8'h7F);
      for (int i = 0; i < 3; i++) op(1, 1, 0, 0, 0, 0);
      clear();
      load(1, 1, 8'h80);
      for (int i = 0; i < 32; i++) op(1, 1, 0, 0, 0, 0);

      // Clear on the FIX edge beats the accumulate; product still updates.
      load(1, 1, 8'h11);
      op(0, 1, 0, 0, 0, 0);
      op(0, 1, 0, 0, 0, 1);

      // Reset four edges into a run.
      op(0, 1, 0, 0, 0, 0);
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      for (int i = 0; i < 4; i++) tick();
      resetn = 1'b0;
      #1;
      check("midrst_busy", bus.busy, 0);
      check("midrst_done", bus.done, 0);
      check("midrst_product", bus.product, 0);
      check("midrst_acc", bus.acc, 0);
      check("midrst_ovf", bus.overflow, 0);
      m_a   = '0;
      m_b   = '0;
      m_acc = '0;
      m_ovf = 1'b0;
      tick();
      resetn = 1'b1;
      dcount = 0;
      for (int i = 0; i < 15; i++) begin
         tick();
         if (bus.done) dcount++;
      end
      check("no_done_after_rst", dcount, 0);
      op(0, 0, 0, 0, 0, 0);
      load(1, 0, 8'h02);
      load(0, 1, 8'h03);
      op(0, 1, 0, 0, 0, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
